ro_measure_scheduler: RTL and testbench
=======================================

// Module: ro_measure_scheduler
// PURPOSE
//   Time-shares one edge counter across NUM_RO ring oscillators.
//   On start, it steps through the rings in ascending index order, skipping any ring whose mask bit is 0.
//   For each ring it enables that ring alone, waits a settle time, and then counts rising edges over a fixed gate window.
//   It reports each count through a valid/ready result port. It sits between the ring array and the readout logic.
// PARAMETERS
//   NUM_RO        6     number of rings controlled (1..16)
//   IDX_W         4     width of result_idx; must satisfy 2**IDX_W >= NUM_RO
//   CNT_W         16    edge-counter width
//   SETTLE_CYCLES 8     clk cycles between ro_en assertion and the gate opening (>=1)
//   GATE_CYCLES   1024  clk cycles the gate stays open (>=1)
// PORTS
//   clk           in   1       system clock
//   rst_n         in   1       asynchronous active-low reset
//   start         in   1       1-cycle pulse; begins a sweep when IDLE
//   abort         in   1       synchronous; ends the sweep immediately
//   mask          in   NUM_RO  rings to measure; sampled on the accepted start
//   ro_in         in   NUM_RO  raw ring outputs (asynchronous to clk)
//   ro_en         out  NUM_RO  ring enables; one-hot or zero
//   busy          out  1       sweep in progress
//   result_valid  out  1       a result is presented
//   result_ready  in   1       consumer accepts the result
//   result_idx    out  IDX_W   ring index of the result
//   result_count  out  CNT_W   rising edges counted in the gate
//   done          out  1       1-cycle pulse at the end of a sweep
// BEHAVIOUR
//   Reset: all outputs are 0, the FSM is in IDLE, and the counter and synchronizers are cleared.
//     rst_n is asynchronous on assertion and synchronous on release.
//   FSM states and transitions:
//     IDLE   -> SELECT when start=1. mask is latched at that point.
//     SELECT -> SETTLE when a lowest remaining masked index exists. That index's bit is cleared and its ro_en bit set.
//     SELECT -> FINISH when no masked index remains.
//     SETTLE -> GATE after SETTLE_CYCLES cycles. The counter is cleared on entry to GATE.
//     GATE   -> REPORT after GATE_CYCLES cycles. ro_en drops to 0 on the same edge.
//     REPORT -> SELECT on the cycle result_valid & result_ready are both 1.
//     FINISH -> IDLE after one cycle. done=1 for that cycle only.
//   busy=1 in every state except IDLE.
//   start is ignored while busy=1.
//   mask=0 at start gives SELECT -> FINISH: done pulses 2 cycles after start, and no result is produced.
//   Edge detection:
//     Each ro_in bit passes through a 2-flop synchronizer followed by a rising-edge detector.
//     Only the selected ring's edges are counted.
//     Counts are exact only when the ring frequency is below clk/2; faster rings alias. This is documented and not corrected.
//   Counter: increments by one per detected edge while in GATE and saturates at 2**CNT_W-1. It does not wrap.
//   Result port:
//     result_valid rises on entry to REPORT.
//     result_idx and result_count stay stable until the transfer completes.
//     result_valid drops in the cycle after the transfer.
//     A consumer that never asserts result_ready stalls the sweep indefinitely; there is no timeout.
//   Synchronizers and enables:
//     Synchronizer flops run continuously.
//     A ring whose ro_en was just asserted delivers edges from its previous state during SETTLE. Those edges are not counted.
//     Exactly one ro_en bit is high in SETTLE and GATE; all are 0 in every other state.
//   abort:
//     Takes priority over every other input in every state.
//     Next edge: ro_en=0, result_valid=0, and the FSM returns to IDLE.
//     Any pending result is discarded, and done is not pulsed.
//     abort in IDLE has no effect.
//   Simultaneous abort and start in IDLE: abort wins and the sweep does not begin.
//   Latency per ring: 1 (SELECT) + SETTLE_CYCLES + GATE_CYCLES cycles, then the handshake.
// TESTING
//   T1: mask=6'b100101, result_ready=1, ro_in[i] toggling at clk/8 -> results for idx 0, 2, 5 in that order, each count=128 +/-1. done pulses once.
//   T2: mask=0, start -> done at start+2, result_valid never rises, busy high for 2 cycles.
//   T3: hold result_ready=0 for 50 cycles in REPORT -> result_idx and result_count stable, ro_en=0, next ring not selected until accepted.
//   T4: CNT_W=8, ring toggling at clk/4, GATE_CYCLES=1024 -> count saturates at 255 and does not wrap.
//   T5: abort mid-GATE of ring 2 -> ro_en=0 next cycle, no result, no done. A new start then runs a full sweep correctly.
//   T6: rst_n low mid-SETTLE, asynchronously -> ro_en, busy and result_valid go to 0 immediately. start repeated during busy -> ignored.
//   Assert throughout: ro_en is one-hot or zero.

Source files
------------

// File: rtl/ro_measure_scheduler_if.sv
// Result port of the ring-oscillator measurement scheduler: one count per
// measured ring, transferred with a valid/ready handshake.
interface ro_measure_scheduler_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
);
  logic             result_valid;
  logic             result_ready;
  logic [IDX_W-1:0] result_idx;
  logic [CNT_W-1:0] result_count;

  modport master (output result_valid, result_idx, result_count, input result_ready);
  modport slave  (input result_valid, result_idx, result_count, output result_ready);
endinterface

// File: rtl/ro_measure_scheduler.sv
// Time-shares one saturating edge counter across NUM_RO ring oscillators:
// enable one ring, let it settle, count synchronized rising edges over a gate.
module ro_measure_scheduler #(
  parameter int unsigned NUM_RO        = 6,
  parameter int unsigned IDX_W         = 4,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned GATE_CYCLES   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_RO-1:0]     mask,
  input  logic [NUM_RO-1:0]     ro_in,
  output logic [NUM_RO-1:0]     ro_en,
  output logic                  busy,
  output logic                  done,
  ro_measure_scheduler_if.master res
);

  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned SEL_W   = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_SETTLE, S_GATE, S_REPORT, S_FINISH
  } state_e;

  state_e state_q, state_d;

  logic [NUM_RO-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [NUM_RO-1:0] edge_c;
  logic [NUM_RO-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_gate_c;
  logic [NUM_RO-1:0] ro_en_q, ro_en_d;
  logic              busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [CNT_W-1:0]  rcnt_q, rcnt_d;
  logic              found_c;
  logic [SEL_W-1:0]  low_idx_c;

  // Synchronizers run continuously, independent of the FSM.
  always_comb begin
    sync1_d = ro_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    edge_c  = sync2_q & ~prev_q;
  end

  // Lowest remaining masked ring.
  always_comb begin
    found_c   = 1'b0;
    low_idx_c = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        found_c   = 1'b1;
        low_idx_c = SEL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; abort overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_SELECT;
      S_SELECT: state_d = found_c ? S_SETTLE : S_FINISH;
      S_SETTLE: if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) state_d = S_GATE;
      S_GATE:   if (tmr_q == TMR_W'(GATE_CYCLES - 1)) state_d = S_REPORT;
      S_REPORT: if (res.result_ready) state_d = S_SELECT;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Datapath and registered outputs, decoded from the upcoming state.
  always_comb begin
    mask_d     = mask_q;
    sel_d      = sel_q;
    tmr_d      = tmr_q + TMR_W'(1);
    cnt_d      = cnt_q;
    ridx_d     = ridx_q;
    rcnt_d     = rcnt_q;
    cnt_gate_c = cnt_q;

    if (state_q == S_GATE && edge_c[sel_q] && cnt_q != CNT_MAX)
      cnt_gate_c = cnt_q + CNT_W'(1);

    if (state_q == S_IDLE && state_d == S_SELECT) mask_d = mask;
    if (state_q == S_SELECT && state_d == S_SETTLE) begin
      mask_d[low_idx_c] = 1'b0;
      sel_d             = low_idx_c;
    end
    if (state_d != state_q) tmr_d = '0;

    if (state_q == S_SETTLE && state_d == S_GATE) cnt_d = '0;
    else if (state_q == S_GATE)                   cnt_d = cnt_gate_c;

    if (state_q == S_GATE && state_d == S_REPORT) begin
      ridx_d = IDX_W'(sel_q);
      rcnt_d = cnt_gate_c;
    end

    ro_en_d = (state_d == S_SETTLE || state_d == S_GATE) ? (NUM_RO'(1) << sel_d) : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FINISH);
    valid_d = (state_d == S_REPORT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      mask_q  <= '0;
      sel_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ro_en_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ridx_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ro_en_q <= ro_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ridx_q  <= ridx_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign ro_en            = ro_en_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign res.result_valid = valid_q;
  assign res.result_idx   = ridx_q;
  assign res.result_count = rcnt_q;

endmodule

// File: tb/tb_ro_measure_scheduler.sv
// Randomized bench for ro_measure_scheduler: ring toggle rates and masks are
// drawn at random, expected results come from edges-per-gate arithmetic.
module tb_ro_measure_scheduler;

  localparam int unsigned NR   = 6;
  localparam int unsigned GATE = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, start8 = 1'b0;
  logic [NR-1:0] mask = '0, mask8 = '0;
  logic [NR-1:0] ro_in = '0;
  logic [NR-1:0] ro_en, ro_en8;
  logic          busy, done, busy8, done8;

  ro_measure_scheduler_if #(.IDX_W(4), .CNT_W(16)) rif ();
  ro_measure_scheduler_if #(.IDX_W(4), .CNT_W(8))  rif8 ();

  ro_measure_scheduler #(.NUM_RO(6), .IDX_W(4), .CNT_W(16), .SETTLE_CYCLES(8), .GATE_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask), .ro_in(ro_in),
    .ro_en(ro_en), .busy(busy), .done(done), .res(rif));

  ro_measure_scheduler #(.NUM_RO(6), .IDX_W(4), .CNT_W(8), .SETTLE_CYCLES(8), .GATE_CYCLES(1024)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .abort(1'b0), .mask(mask8), .ro_in(ro_in),
    .ro_en(ro_en8), .busy(busy8), .done(done8), .res(rif8));

  always #5 clk = ~clk;

  // Ring i toggles every half_per[i] clocks: period 2*half_per[i].
  int half_per [NR] = '{default: 4};
  int phase    [NR] = '{default: 0};
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (phase[i] + 1 >= half_per[i]) begin
        phase[i] <= 0;
        ro_in[i] <= ~ro_in[i];
      end else begin
        phase[i] <= phase[i] + 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol = 0);
    n_checks++;
    if (got < exp - tol || got > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic pulse_start(input logic [NR-1:0] m);
    @(negedge clk);
    start = 1'b1;
    mask  = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full sweep against the model: masked rings in ascending order, each with
  // GATE / period edges (+/-1 for window phase).
  task automatic run_sweep(input logic [NR-1:0] m, input int stall_pct, input int hold, input bit restart);
    int          q_idx[$];
    int          q_cnt[$];
    int          vcyc;
    int          dones;
    bit          fin;
    bit          stalled;
    logic [3:0]  pidx;
    logic [15:0] pcnt;
    vcyc = 0; dones = 0; fin = 0; stalled = 0; pidx = '0; pcnt = '0;
    for (int i = 0; i < NR; i++) begin
      if (m[i]) begin
        q_idx.push_back(i);
        q_cnt.push_back(GATE / (2 * half_per[i]));
      end
    end
    rif.result_ready = 1'b0;
    pulse_start(m);
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 9000 && !fin; cyc++) begin
      start = restart && (cyc == 20);
      if (restart && cyc == 20) mask = ~m;
      check("ro_en_onehot", $onehot0(ro_en), 1);
      if (stalled) begin
        check("valid_held", rif.result_valid, 1);
        check("idx_stable", rif.result_idx, pidx);
        check("count_stable", rif.result_count, pcnt);
        check("ro_en_stall", ro_en, 0);
      end
      stalled = 1'b0;
      if (rif.result_valid) begin
        if (vcyc == 0) check("ro_en_report", ro_en, 0);
        rif.result_ready = (vcyc >= hold) && ($urandom_range(99) >= stall_pct);
        if (rif.result_ready) begin
          if (q_idx.size() == 0) begin
            check("extra_result", 1, 0);
          end else begin
            check("result_idx", rif.result_idx, q_idx.pop_front());
            check("result_count", rif.result_count, q_cnt.pop_front(), 1);
          end
          vcyc = 0;
        end else begin
          stalled = 1'b1;
          pidx    = rif.result_idx;
          pcnt    = rif.result_count;
          vcyc++;
        end
      end else begin
        rif.result_ready = (hold == 0) && ($urandom_range(99) >= stall_pct);
      end
      if (done) begin
        dones++;
        fin = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    start = 1'b0;
    if (!fin) check("sweep_timeout", 0, 1);
    check("results_left", q_idx.size(), 0);
    check("done_count", dones, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    logic [NR-1:0] m;
    int            n;
    bit            seen;
    rif.result_ready  = 1'b0;
    rif8.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ro_en", ro_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", rif.result_valid, 0);
    check("rst_idx", rif.result_idx, 0);
    check("rst_count", rif.result_count, 0);
    check("rst_busy8", busy8, 0);

    // Abort and start together in IDLE: abort wins.
    start = 1'b1; abort = 1'b1; mask = 6'b000001;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("abort_start_idle", busy, 0);

    // Empty mask: done two cycles after start, no result.
    pulse_start(6'b000000);
    check("empty_busy1", busy, 1);
    check("empty_done1", done, 0);
    @(negedge clk);
    check("empty_busy2", busy, 1);
    check("empty_done2", done, 1);
    check("empty_valid", rif.result_valid, 0);
    @(negedge clk);
    check("empty_busy3", busy, 0);
    check("empty_done3", done, 0);

    // Rings at clk/8, mask 100101.
    run_sweep(6'b100101, 0, 0, 0);

    // Long consumer stall in REPORT.
    run_sweep(6'b001000, 0, 50, 0);

    // Saturation on the 8-bit counter: clk/4 ring gives ~256 edges.
    half_per[0] = 2;
    repeat (10) @(negedge clk);
    start8 = 1'b1; mask8 = 6'b000001;
    @(negedge clk);
    start8 = 1'b0;
    rif8.result_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 1200 && !seen; c++) begin
      check("ro_en8_onehot", $onehot0(ro_en8), 1);
      if (rif8.result_valid) begin
        seen = 1'b1;
        check("sat_count", rif8.result_count, 255);
        check("sat_idx", rif8.result_idx, 0);
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) check("sat_timeout", 0, 1);
    repeat (4) @(negedge clk);
    check("sat_busy8", busy8, 0);
    half_per[0] = 4;

    // Abort in the gate of ring 2.
    rif.result_ready = 1'b1;
    pulse_start(6'b000110);
    seen = 1'b0;
    for (int c = 0; c < 1500 && !seen; c++) begin
      if (rif.result_valid) begin
        seen = 1'b1;
        check("pre_abort_idx", rif.result_idx, 1);
      end
      @(negedge clk);
    end
    if (!seen) check("pre_abort_timeout", 0, 1);
    seen = 1'b0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (ro_en == 6'b000100) seen = 1'b1;
      else @(negedge clk);
    end
    check("ring2_enabled", seen, 1);
    repeat (300) @(negedge clk);
    check("ring2_in_gate", ro_en, 6'b000100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_ro_en", ro_en, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", rif.result_valid, 0);
    n = 0;
    for (int c = 0; c < 1200; c++) begin
      if (rif.result_valid || done || busy) n++;
      @(negedge clk);
    end
    check("abort_quiet", n, 0);
    run_sweep(6'b110011, 20, 2, 0);

    // Asynchronous reset in the middle of SETTLE.
    pulse_start(6'b000001);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      if (ro_en != 0) seen = 1'b1;
      else @(negedge clk);
    end
    check("settle_reached", seen, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ro_en", ro_en, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", rif.result_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_idle", busy, 0);

    // Repeated start while busy is ignored.
    run_sweep(6'b010101, 10, 0, 1);

    // Randomized sweeps.
    repeat (3) begin
      for (int i = 0; i < NR; i++) half_per[i] = $urandom_range(8, 2);
      m = NR'($urandom_range(63, 1));
      repeat (20) @(negedge clk);
      run_sweep(m, 30, $urandom_range(4, 0), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
